alu_writeback: RTL and testbench
================================

ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset, sampled on rising edge of clk.
REQ-003 SHALL have port wb_valid, input, 1, producer holds a valid ALU result/command.
REQ-004 SHALL have port wb_ready, output, 1, block can accept a command this cycle.
REQ-005 SHALL have port wb_op, input, 5, ALU operation code (0x00-0x12 defined, as issued to the ALU).
REQ-006 SHALL have port wb_dest, input, 2, destination: 00 none, 01 ACC, 10 B, 11 PSW.
REQ-007 SHALL have port alu_ans, input, 8, ALU result byte.
REQ-008 SHALL have port alu_psw, input, 8, ALU next-flag byte (bit7 CY, bit2 OV).
REQ-009 SHALL have ports acc, b_reg, psw, output, 8 each, architectural ACC, B and PSW registers.
REQ-010 SHALL have port busy, output, 1, MUL/DIV iteration in progress.
REQ-011 SHALL have port done, output, 1, one-cycle pulse marking command completion.

Function
REQ-012 SHALL implement states IDLE, MUL, DIV; wb_ready = 1 only in IDLE and not in reset; busy = 1 only in MUL or DIV.
REQ-013 SHALL accept a command on an edge where wb_valid && wb_ready; wb_valid while wb_ready = 0 is ignored (not queued).
REQ-014 For accepted op not 0x05/0x06: SHALL commit at the accept edge: dest ACC -> acc <= alu_ans; dest B -> b_reg <= alu_ans; dest PSW -> psw[7:1] <= alu_ans[7:1]; dest none -> no data write.
REQ-015 Flag merge at same edge: ops 0x00, 0x01, 0x0F, 0x11 -> psw[7] <= alu_psw[7]; ops 0x02, 0x03 -> psw[2] <= alu_psw[2]; other psw bits unchanged unless dest PSW.
REQ-016 psw[0] SHALL always equal XOR-reduction of acc (updated on the same edge acc changes; never written from alu_ans).
REQ-017 Undefined op (>0x12) SHALL be accepted with no register change and normal done pulse.
REQ-018 done SHALL be 1 for exactly the cycle after any commit edge, else 0.
REQ-019 Op 0x05 (MUL AB): at accept edge E0 SHALL snapshot acc and b_reg, clear 4-bit counter, enter MUL; wb_dest/alu_ans ignored.
REQ-020 MUL SHALL perform one shift-add iteration per edge E1..E8, forming a 16-bit unsigned product; at E8 acc <= product[7:0], b_reg <= product[15:8], psw[7] <= 0, psw[2] <= (product[15:8] != 0), return to IDLE.
REQ-021 Op 0x06 (DIV AB) with b_reg != 0: snapshot at E0, enter DIV, one restoring-division iteration per edge E1..E8; at E8 acc <= quotient, b_reg <= remainder, psw[7] <= 0, psw[2] <= 0, return to IDLE.
REQ-022 Op 0x06 with b_reg == 0: SHALL not enter DIV; at E0 acc and b_reg unchanged, psw[7] <= 0, psw[2] <= 1; done at next cycle.
REQ-023 MUL/DIV latency: wb_ready low from cycle after E0 through cycle ending at E8; done high in cycle after E8; back-to-back accept possible at E9.
REQ-024 Intermediate iteration state SHALL not be visible on acc/b_reg/psw before E8.

Reset
REQ-025 On rst = 1 at an edge: acc = 0x00, b_reg = 0x00, psw = 0x00, state IDLE, counter 0, done = 0, busy = 0; wb_ready = 0 while rst high, 1 in first cycle after rst deasserts.
REQ-026 rst during MUL/DIV SHALL abort with no commit and no done pulse; rst has priority over accept on the same edge.

Verification
REQ-027 Reset: rst high 2 cycles -> acc = 0x00, b_reg = 0x00, psw = 0x00, busy = 0, done = 0; wb_ready = 1 after release.
REQ-028 Load: op 0x00, dest ACC, alu_ans = 0x50, alu_psw = 0x80 -> acc = 0x50, psw[7] = 1, psw[0] = 0, done 1 cycle later.
REQ-029 MUL: acc = 0x50, b_reg = 0xA0, op 0x05 -> after 8 iterations acc = 0x00, b_reg = 0x32, psw[2] = 1, psw[7] = 0, psw[0] = 0, done in cycle after E8, wb_ready = 0 throughout.
REQ-030 DIV: acc = 0xFB, b_reg = 0x12, op 0x06 -> acc = 0x0D, b_reg = 0x11, psw[2] = 0, psw[7] = 0, psw[0] = 1.
REQ-031 DIV by zero: acc = 0x37, b_reg = 0x00, op 0x06 -> acc = 0x37, b_reg = 0x00, psw[2] = 1, psw[7] = 0, busy never 1, done in next cycle.
REQ-032 Abort: rst pulsed at E4 of MUL (acc = 0xFF, b_reg = 0xFF) -> all registers 0x00, no done pulse, wb_ready = 1 after release; wb_valid held during busy is not accepted.

Source files
------------

// File: rtl/alu_writeback_if.sv
// Command/result bus between the ALU issue stage and the writeback block.
interface alu_writeback_if;
  logic       wb_valid;
  logic       wb_ready;
  logic [4:0] wb_op;
  logic [1:0] wb_dest;
  logic [7:0] alu_ans;
  logic [7:0] alu_psw;

  modport master (output wb_valid, wb_op, wb_dest, alu_ans, alu_psw, input wb_ready);
  modport slave  (input wb_valid, wb_op, wb_dest, alu_ans, alu_psw, output wb_ready);
endinterface

// File: rtl/alu_writeback.sv
// Architectural ACC/B/PSW writeback with flag merge and iterative 8x8 MUL / 8/8 DIV.
module alu_writeback (
  input  logic                clk,
  input  logic                rst,
  alu_writeback_if.slave      wb,
  output logic [7:0]          acc,
  output logic [7:0]          b_reg,
  output logic [7:0]          psw,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic [7:0]  op_a, op_b;
  logic [15:0] prod, prod_nxt, mul_term;
  logic [7:0]  rem, rem_nxt, dvd, dvd_nxt;
  logic [8:0]  div_trial, div_diff;
  logic        div_ge;
  logic [7:1]  psw_r;
  logic        accept, last_iter;
  logic        unused_bits;

  assign wb.wb_ready = (state == IDLE) && !rst;
  assign accept      = wb.wb_valid && wb.wb_ready;
  assign busy        = (state != IDLE);
  assign last_iter   = (cnt == 4'd7);
  // Parity bit is derived from acc rather than stored, so it tracks acc on every edge.
  assign psw         = {psw_r, ^acc};
  assign unused_bits = ^{wb.alu_ans[0], wb.alu_psw[6:3], wb.alu_psw[1:0], div_diff[8]};

  // Iteration datapath: shift-add multiply, restoring divide
  always_comb begin
    mul_term  = op_b[cnt[2:0]] ? ({8'h00, op_a} << cnt[2:0]) : 16'h0000;
    prod_nxt  = prod + mul_term;
    div_trial = {rem, dvd[7]};
    div_diff  = div_trial - {1'b0, op_b};
    div_ge    = (div_trial >= {1'b0, op_b});
    rem_nxt   = div_ge ? div_diff[7:0] : div_trial[7:0];
    dvd_nxt   = {dvd[6:0], div_ge};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && wb.wb_op == 5'h05)
          state_nxt = MUL;
        else if (accept && wb.wb_op == 5'h06 && b_reg != 8'h00)
          state_nxt = DIV;
      end
      MUL, DIV: if (last_iter) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= 8'h00;
      b_reg <= 8'h00;
      psw_r <= 7'h00;
      cnt   <= 4'd0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (wb.wb_op == 5'h05) begin
              op_a <= acc;
              op_b <= b_reg;
              prod <= 16'h0000;
              cnt  <= 4'd0;
            end else if (wb.wb_op == 5'h06) begin
              if (b_reg != 8'h00) begin
                op_a <= acc;
                op_b <= b_reg;
                rem  <= 8'h00;
                dvd  <= acc;
                cnt  <= 4'd0;
              end else begin
                psw_r[7] <= 1'b0;
                psw_r[2] <= 1'b1;
                done     <= 1'b1;
              end
            end else begin
              done <= 1'b1;
              if (wb.wb_op <= 5'h12) begin
                case (wb.wb_dest)
                  2'b01:   acc   <= wb.alu_ans;
                  2'b10:   b_reg <= wb.alu_ans;
                  2'b11:   psw_r <= wb.alu_ans[7:1];
                  default: ;
                endcase
                // Flag merge follows the destination write so the ALU flags win.
                if (wb.wb_op == 5'h00 || wb.wb_op == 5'h01 ||
                    wb.wb_op == 5'h0F || wb.wb_op == 5'h11)
                  psw_r[7] <= wb.alu_psw[7];
                if (wb.wb_op == 5'h02 || wb.wb_op == 5'h03)
                  psw_r[2] <= wb.alu_psw[2];
              end
            end
          end
        end
        MUL: begin
          prod <= prod_nxt;
          cnt  <= cnt + 4'd1;
          if (last_iter) begin
            acc      <= prod_nxt[7:0];
            b_reg    <= prod_nxt[15:8];
            psw_r[7] <= 1'b0;
            psw_r[2] <= |prod_nxt[15:8];
            done     <= 1'b1;
          end
        end
        DIV: begin
          rem <= rem_nxt;
          dvd <= dvd_nxt;
          cnt <= cnt + 4'd1;
          if (last_iter) begin
            acc      <= dvd_nxt;
            b_reg    <= rem_nxt;
            psw_r[7] <= 1'b0;
            psw_r[2] <= 1'b0;
            done     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_writeback.sv
// Directed-vector bench for alu_writeback: loads, flag merge, MUL, DIV, divide-by-zero, abort.
module tb_alu_writeback;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] acc, b_reg, psw;
  logic       busy, done;
  int         vectors    = 0;
  int         miscompares = 0;

  alu_writeback_if bus ();

  alu_writeback dut (
    .clk   (clk),
    .rst   (rst),
    .wb    (bus.slave),
    .acc   (acc),
    .b_reg (b_reg),
    .psw   (psw),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [4:0] op, input logic [1:0] dest,
                       input logic [7:0] ans, input logic [7:0] flags);
    bus.wb_valid = 1'b1;
    bus.wb_op    = op;
    bus.wb_dest  = dest;
    bus.alu_ans  = ans;
    bus.alu_psw  = flags;
    tick();
    bus.wb_valid = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    bus.wb_valid = 1'b0;
    bus.wb_op    = 5'h00;
    bus.wb_dest  = 2'b00;
    bus.alu_ans  = 8'h00;
    bus.alu_psw  = 8'h00;

    tick();
    tick();
    check("rst_acc", acc, 8'h00);
    check("rst_b", b_reg, 8'h00);
    check("rst_psw", psw, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ready_low", bus.wb_ready, 1'b0);
    rst = 1'b0;
    #1;
    check("rel_ready", bus.wb_ready, 1'b1);

    // Load ACC with carry merge
    issue(5'h00, 2'b01, 8'h50, 8'h80);
    check("ld_acc", acc, 8'h50);
    check("ld_psw", psw, 8'h80);
    check("ld_done", done, 1'b1);
    tick();
    check("ld_done_drop", done, 1'b0);

    issue(5'h08, 2'b10, 8'hA0, 8'hFF);
    check("ld_b", b_reg, 8'hA0);
    check("ld_b_psw", psw, 8'h80);

    // MUL 0x50 * 0xA0 = 0x3200
    issue(5'h05, 2'b01, 8'hFF, 8'hFF);
    check("mul_e0_busy", busy, 1'b1);
    check("mul_e0_ready", bus.wb_ready, 1'b0);
    check("mul_e0_done", done, 1'b0);
    for (int i = 0; i < 7; i++) begin
      tick();
      check("mul_iter_ready", bus.wb_ready, 1'b0);
      check("mul_iter_acc", acc, 8'h50);
      check("mul_iter_b", b_reg, 8'hA0);
      check("mul_iter_done", done, 1'b0);
    end
    tick();
    check("mul_acc", acc, 8'h00);
    check("mul_b", b_reg, 8'h32);
    check("mul_psw", psw, 8'h04);
    check("mul_done", done, 1'b1);
    check("mul_ready", bus.wb_ready, 1'b1);
    check("mul_busy", busy, 1'b0);

    // OV merge with no destination write
    issue(5'h02, 2'b00, 8'hFF, 8'h00);
    check("ov_acc", acc, 8'h00);
    check("ov_psw", psw, 8'h00);

    // DIV 0xFB / 0x12 = 0x0D rem 0x11
    issue(5'h01, 2'b01, 8'hFB, 8'h00);
    check("div_ld_psw", psw, 8'h01);
    issue(5'h08, 2'b10, 8'h12, 8'h00);
    issue(5'h06, 2'b00, 8'h00, 8'h00);
    for (int i = 0; i < 7; i++) begin
      tick();
      check("div_iter_busy", busy, 1'b1);
      check("div_iter_acc", acc, 8'hFB);
    end
    tick();
    check("div_acc", acc, 8'h0D);
    check("div_b", b_reg, 8'h11);
    check("div_psw", psw, 8'h01);
    check("div_done", done, 1'b1);

    // PSW destination keeps parity derived from acc
    issue(5'h08, 2'b11, 8'hFE, 8'h00);
    check("pswd_set", psw, 8'hFF);
    issue(5'h08, 2'b11, 8'h00, 8'h00);
    check("pswd_clr", psw, 8'h01);

    // Divide by zero
    issue(5'h08, 2'b01, 8'h37, 8'h00);
    issue(5'h08, 2'b10, 8'h00, 8'h00);
    issue(5'h06, 2'b00, 8'h00, 8'h00);
    check("dz_acc", acc, 8'h37);
    check("dz_b", b_reg, 8'h00);
    check("dz_psw", psw, 8'h05);
    check("dz_busy", busy, 1'b0);
    check("dz_done", done, 1'b1);
    tick();
    check("dz_busy2", busy, 1'b0);
    check("dz_done2", done, 1'b0);

    // Undefined op leaves registers alone but still completes
    issue(5'h15, 2'b01, 8'hAA, 8'h80);
    check("undef_acc", acc, 8'h37);
    check("undef_psw", psw, 8'h05);
    check("undef_done", done, 1'b1);

    // Abort MUL with reset at E4; a held command during busy must be ignored
    issue(5'h08, 2'b01, 8'hFF, 8'h00);
    issue(5'h08, 2'b10, 8'hFF, 8'h00);
    check("ab_psw", psw, 8'h04);
    issue(5'h05, 2'b00, 8'h00, 8'h00);
    bus.wb_valid = 1'b1;
    bus.wb_op    = 5'h08;
    bus.wb_dest  = 2'b01;
    bus.alu_ans  = 8'h11;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ab_hold_acc", acc, 8'hFF);
      check("ab_hold_busy", busy, 1'b1);
    end
    bus.wb_valid = 1'b0;
    rst = 1'b1;
    tick();
    check("ab_acc", acc, 8'h00);
    check("ab_b", b_reg, 8'h00);
    check("ab_psw0", psw, 8'h00);
    check("ab_busy", busy, 1'b0);
    check("ab_done", done, 1'b0);
    check("ab_ready_rst", bus.wb_ready, 1'b0);
    rst = 1'b0;
    #1;
    check("ab_ready", bus.wb_ready, 1'b1);
    tick();
    check("ab_no_done", done, 1'b0);
    check("ab_acc2", acc, 8'h00);
    check("ab_b2", b_reg, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
